draw_cmdfetch: RTL and testbench

- Consumer end of the drawing command FIFO.
- Pops 32-bit words from the FIFO that register writes to 0x200C fill. Assembles them into 1–3-word commands.
- Presents each complete command to the drawing engine over a valid/ready handshake.
- Drives the DRAW_BUSY status and a one-cycle end-of-list pulse, which feeds DRW_IRQ generation.

---
 rtl/draw_cmdfetch_if.sv | 37 +++
 rtl/draw_cmdfetch.sv | 142 ++++++++++++++
 tb/tb_draw_cmdfetch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_cmdfetch_if.sv
// Bus bundle between the drawing command FIFO, the command fetcher and the drawing engine.
// The master side is the fetcher: it pops the FIFO and offers descriptors.
interface draw_cmdfetch_if;
  logic        CMD_RD_EN;
  logic [31:0] CMD_RDATA;
  logic        CMD_EMPTY;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  OUT_OPC;
  logic [23:0] OUT_HDR;
  logic [31:0] OUT_ARG0;
  logic [31:0] OUT_ARG1;

  modport master (
    output CMD_RD_EN,
    input  CMD_RDATA,
    input  CMD_EMPTY,
    output OUT_VALID,
    input  OUT_READY,
    output OUT_OPC,
    output OUT_HDR,
    output OUT_ARG0,
    output OUT_ARG1
  );

  modport slave (
    input  CMD_RD_EN,
    output CMD_RDATA,
    output CMD_EMPTY,
    input  OUT_VALID,
    output OUT_READY,
    input  OUT_OPC,
    input  OUT_HDR,
    input  OUT_ARG0,
    input  OUT_ARG1
  );
endinterface

// File: rtl/draw_cmdfetch.sv
// Drawing command fetcher: pops FIFO words, assembles 1-3 word commands and
// hands complete descriptors to the drawing engine.
module draw_cmdfetch #(
  parameter int TMO_CYCLES = 1024
) (
  input  logic CLK,
  input  logic ARSTN,
  input  logic REG_EXE,
  input  logic REG_RST,
  draw_cmdfetch_if.master bus,
  output logic DRAW_BUSY,
  output logic EOD_PULSE,
  output logic CMD_ERR
);

  localparam int TW = $clog2(TMO_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  localparam logic [7:0] OPC_NOP      = 8'h00;
  localparam logic [7:0] OPC_SETFRAME = 8'h01;
  localparam logic [7:0] OPC_SETCOLOR = 8'h02;
  localparam logic [7:0] OPC_PATBLT   = 8'h03;
  localparam logic [7:0] OPC_EODL     = 8'h0F;

  typedef enum logic [2:0] {
    IDLE, HDR_RD, HDR_CAP, ARG_RD, ARG_CAP, ISSUE, NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     hdr_q, arg0_q, arg1_q;
  logic [1:0]      arg_cnt_q;
  logic [TW-1:0]   tmo_cnt_q;
  logic            err_q;

  logic [7:0]      rd_opc;
  logic            rd_unknown;
  logic [1:0]      need_args;
  logic            arg_last;
  logic            tmo_hit;

  assign rd_opc     = bus.CMD_RDATA[31:24];
  assign rd_unknown = !(rd_opc inside {OPC_NOP, OPC_SETFRAME, OPC_SETCOLOR, OPC_PATBLT, OPC_EODL});
  assign need_args  = (hdr_q[31:24] == OPC_PATBLT) ? 2'd2 : 2'd1;
  assign arg_last   = ((arg_cnt_q + 2'd1) == need_args);
  assign tmo_hit    = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN)       state_q <= IDLE;
    else if (REG_RST) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (REG_EXE && !bus.CMD_EMPTY) state_d = HDR_RD;
      HDR_RD:  state_d = HDR_CAP;
      HDR_CAP: begin
        case (rd_opc)
          OPC_SETCOLOR:             state_d = ISSUE;
          OPC_SETFRAME, OPC_PATBLT: state_d = ARG_RD;
          OPC_EODL:                 state_d = IDLE;
          default:                  state_d = NEXT;
        endcase
      end
      ARG_RD: begin
        if (!bus.CMD_EMPTY) state_d = ARG_CAP;
        else if (tmo_hit)   state_d = IDLE;
      end
      ARG_CAP: state_d = arg_last ? ISSUE : ARG_RD;
      ISSUE:   if (bus.OUT_READY) state_d = NEXT;
      NEXT:    state_d = (REG_EXE && !bus.CMD_EMPTY) ? HDR_RD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads and the end-of-list pulse are suppressed in a flush cycle so nothing leaks past REG_RST.
  always_comb begin
    bus.CMD_RD_EN = 1'b0;
    bus.OUT_VALID = 1'b0;
    EOD_PULSE     = 1'b0;
    DRAW_BUSY     = (state_q != IDLE);
    case (state_q)
      HDR_RD, ARG_RD: bus.CMD_RD_EN = !REG_RST && !bus.CMD_EMPTY;
      HDR_CAP:        EOD_PULSE     = !REG_RST && (rd_opc == OPC_EODL);
      ISSUE:          bus.OUT_VALID = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) begin
      hdr_q     <= '0;
      arg0_q    <= '0;
      arg1_q    <= '0;
      arg_cnt_q <= '0;
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (REG_RST) begin
      hdr_q     <= '0;
      arg0_q    <= '0;
      arg1_q    <= '0;
      arg_cnt_q <= '0;
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        HDR_CAP: begin
          hdr_q     <= bus.CMD_RDATA;
          arg0_q    <= '0;
          arg1_q    <= '0;
          arg_cnt_q <= '0;
          tmo_cnt_q <= '0;
          if (rd_unknown) err_q <= 1'b1;
        end
        ARG_RD: begin
          if (!bus.CMD_EMPTY) begin
            tmo_cnt_q <= '0;
          end else if (tmo_hit) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        ARG_CAP: begin
          if (arg_cnt_q == 2'd0) arg0_q <= bus.CMD_RDATA;
          else                   arg1_q <= bus.CMD_RDATA;
          arg_cnt_q <= arg_cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.OUT_OPC  = hdr_q[31:24];
  assign bus.OUT_HDR  = hdr_q[23:0];
  assign bus.OUT_ARG0 = arg0_q;
  assign bus.OUT_ARG1 = arg1_q;
  assign CMD_ERR      = err_q;

endmodule

// File: tb/tb_draw_cmdfetch.sv
// Directed bench for draw_cmdfetch: a queue-backed FIFO model feeds the block,
// and every check goes through check_output against hand-computed values.
module tb_draw_cmdfetch;
  logic CLK;
  logic ARSTN;
  logic REG_EXE;
  logic REG_RST;
  logic DRAW_BUSY;
  logic EOD_PULSE;
  logic CMD_ERR;

  draw_cmdfetch_if bus();

  draw_cmdfetch #(.TMO_CYCLES(16)) dut (
    .CLK       (CLK),
    .ARSTN     (ARSTN),
    .REG_EXE   (REG_EXE),
    .REG_RST   (REG_RST),
    .bus       (bus),
    .DRAW_BUSY (DRAW_BUSY),
    .EOD_PULSE (EOD_PULSE),
    .CMD_ERR   (CMD_ERR)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] fifo[$];
  logic [31:0] push_q[$];

  int  rd_cnt = 0;
  int  eod_cnt = 0;
  int  valid_cnt = 0;
  int  rd_viol = 0;
  logic prev_rd = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // FIFO model: pops on read enable, flushes on REG_RST, takes new words at the clock edge.
  always @(posedge CLK) begin
    if (REG_RST) fifo.delete();
    else if (bus.CMD_RD_EN && fifo.size() > 0) bus.CMD_RDATA <= fifo.pop_front();
    while (push_q.size() > 0) fifo.push_back(push_q.pop_front());
    bus.CMD_EMPTY <= (fifo.size() == 0);
  end

  always @(negedge CLK) begin
    if (bus.CMD_RD_EN) rd_cnt++;
    if (EOD_PULSE) eod_cnt++;
    if (bus.OUT_VALID) valid_cnt++;
    if (bus.CMD_RD_EN && (bus.CMD_EMPTY || prev_rd)) rd_viol++;
    prev_rd = bus.CMD_RD_EN;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    push_q.push_back(w);
  endtask

  task automatic wait_rd(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.CMD_RD_EN) break;
      tick(1);
    end
    check_output(tag, bus.CMD_RD_EN, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.OUT_VALID) break;
      tick(1);
    end
    check_output(tag, bus.OUT_VALID, 1'b1);
  endtask

  task automatic pulse_rst;
    REG_RST = 1'b1;
    tick(1);
    REG_RST = 1'b0;
  endtask

  int rd_base, eod_base, valid_base;

  initial begin
    ARSTN = 1'b0;
    REG_EXE = 1'b0;
    REG_RST = 1'b0;
    bus.OUT_READY = 1'b0;
    #1;
    check_output("rst_rd_en", bus.CMD_RD_EN, 1'b0);
    check_output("rst_valid", bus.OUT_VALID, 1'b0);
    check_output("rst_busy", DRAW_BUSY, 1'b0);
    check_output("rst_eod", EOD_PULSE, 1'b0);
    check_output("rst_err", CMD_ERR, 1'b0);
    check_output("rst_opc", bus.OUT_OPC, 8'h00);
    check_output("rst_arg0", bus.OUT_ARG0, 32'h0);
    tick(3);
    ARSTN = 1'b1;
    tick(2);

    // SETCOLOR: one read, descriptor two cycles later, busy drops after NEXT
    REG_EXE = 1'b1;
    bus.OUT_READY = 1'b1;
    rd_base = rd_cnt;
    push(32'h02ABCDEF);
    wait_rd("sc_rd_seen");
    tick(1);
    check_output("sc_valid_t1", bus.OUT_VALID, 1'b0);
    tick(1);
    check_output("sc_valid_t2", bus.OUT_VALID, 1'b1);
    check_output("sc_opc", bus.OUT_OPC, 8'h02);
    check_output("sc_hdr", bus.OUT_HDR, 24'hABCDEF);
    check_output("sc_arg0", bus.OUT_ARG0, 32'h0);
    check_output("sc_arg1", bus.OUT_ARG1, 32'h0);
    tick(1);
    check_output("sc_valid_drop", bus.OUT_VALID, 1'b0);
    check_output("sc_busy_next", DRAW_BUSY, 1'b1);
    tick(1);
    check_output("sc_busy_idle", DRAW_BUSY, 1'b0);
    tick(2);
    check_output("sc_rd_count", rd_cnt - rd_base, 1);

    // PATBLT with the engine stalling five cycles
    bus.OUT_READY = 1'b0;
    rd_base = rd_cnt;
    valid_base = valid_cnt;
    push(32'h03000000);
    push(32'h00100020);
    push(32'h00400030);
    wait_rd("pb_rd_seen");
    tick(5);
    check_output("pb_valid_t5", bus.OUT_VALID, 1'b0);
    tick(1);
    check_output("pb_valid_t6", bus.OUT_VALID, 1'b1);
    check_output("pb_arg0_first", bus.OUT_ARG0, 32'h00100020);
    check_output("pb_arg1_first", bus.OUT_ARG1, 32'h00400030);
    tick(5);
    bus.OUT_READY = 1'b1;
    check_output("pb_valid_held", bus.OUT_VALID, 1'b1);
    check_output("pb_opc_held", bus.OUT_OPC, 8'h03);
    check_output("pb_arg0_held", bus.OUT_ARG0, 32'h00100020);
    check_output("pb_arg1_held", bus.OUT_ARG1, 32'h00400030);
    tick(1);
    check_output("pb_valid_drop", bus.OUT_VALID, 1'b0);
    tick(3);
    check_output("pb_valid_cycles", valid_cnt - valid_base, 6);
    check_output("pb_rd_count", rd_cnt - rd_base, 3);

    // SETFRAME header with no argument: abort after 16 empty cycles
    valid_base = valid_cnt;
    push(32'h01000000);
    wait_rd("to_rd_seen");
    tick(17);
    check_output("to_err_before", CMD_ERR, 1'b0);
    check_output("to_busy_before", DRAW_BUSY, 1'b1);
    tick(1);
    check_output("to_err_after", CMD_ERR, 1'b1);
    check_output("to_busy_after", DRAW_BUSY, 1'b0);
    check_output("to_no_valid", valid_cnt - valid_base, 0);
    pulse_rst();
    check_output("to_err_cleared", CMD_ERR, 1'b0);

    // NOP, unknown opcode, EODL
    valid_base = valid_cnt;
    eod_base = eod_cnt;
    rd_base = rd_cnt;
    push(32'h00000000);
    push(32'h7F000000);
    push(32'h0F000000);
    tick(15);
    check_output("seq_no_valid", valid_cnt - valid_base, 0);
    check_output("seq_err", CMD_ERR, 1'b1);
    check_output("seq_eod_count", eod_cnt - eod_base, 1);
    check_output("seq_busy", DRAW_BUSY, 1'b0);
    check_output("seq_rd_count", rd_cnt - rd_base, 3);
    pulse_rst();

    // REG_EXE dropped while fetching the SETFRAME argument
    rd_base = rd_cnt;
    push(32'h01123456);
    push(32'hCAFEF00D);
    push(32'h02000001);
    wait_rd("exe_rd_seen");
    tick(2);
    REG_EXE = 1'b0;
    check_output("exe_arg_rd", bus.CMD_RD_EN, 1'b1);
    tick(2);
    check_output("exe_valid", bus.OUT_VALID, 1'b1);
    check_output("exe_opc", bus.OUT_OPC, 8'h01);
    check_output("exe_hdr", bus.OUT_HDR, 24'h123456);
    check_output("exe_arg0", bus.OUT_ARG0, 32'hCAFEF00D);
    check_output("exe_arg1", bus.OUT_ARG1, 32'h0);
    tick(6);
    check_output("exe_rd_count", rd_cnt - rd_base, 2);
    check_output("exe_busy", DRAW_BUSY, 1'b0);

    // REG_RST while a descriptor waits in ISSUE
    bus.OUT_READY = 1'b0;
    REG_EXE = 1'b1;
    wait_valid("rr_valid_seen");
    check_output("rr_opc", bus.OUT_OPC, 8'h02);
    pulse_rst();
    check_output("rr_valid_off", bus.OUT_VALID, 1'b0);
    check_output("rr_busy_off", DRAW_BUSY, 1'b0);

    // REG_RST in a read cycle must mask the read enable
    push(32'h03000000);
    push(32'h00000001);
    push(32'h00000002);
    wait_rd("rrd_rd_seen");
    REG_RST = 1'b1;
    #1;
    check_output("rrd_rd_masked", bus.CMD_RD_EN, 1'b0);
    tick(1);
    REG_RST = 1'b0;
    check_output("rrd_busy", DRAW_BUSY, 1'b0);

    // Asynchronous reset mid-command
    push(32'h03000000);
    push(32'h00000011);
    push(32'h00000022);
    wait_rd("ar_rd_seen");
    tick(1);
    bus.OUT_READY = 1'b1;
    REG_RST = 1'b0;
    tick(1);
    check_output("ar_pre_rd", bus.CMD_RD_EN, 1'b1);
    ARSTN = 1'b0;
    #1;
    check_output("ar_rd_en", bus.CMD_RD_EN, 1'b0);
    check_output("ar_busy", DRAW_BUSY, 1'b0);
    check_output("ar_valid", bus.OUT_VALID, 1'b0);
    check_output("ar_eod", EOD_PULSE, 1'b0);
    check_output("ar_err", CMD_ERR, 1'b0);
    check_output("ar_hdr", bus.OUT_HDR, 24'h0);

    check_output("rd_rules", rd_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
